// File: rtl/pipeline_controller_pkg.sv
// pipeline_controller_pkg: shared state/forwarding types and reset polarity for the pipeline controller
package pipeline_controller_pkg;
    localparam logic RESET = 1'b1;
    typedef enum logic [1:0] {S_DRAIN, S_RUN, S_MEM_WAIT, S_HALT} ctrl_state_t;
    typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
endpackage

// File: rtl/forwarding_unit.sv
// forwarding_unit: EX operand selects from MEM/WB destination matches, MEM result taking precedence
module forwarding_unit
    import pipeline_controller_pkg::*;
#(
    parameter int RA = 5
) (
    input  logic [RA-1:0] ex_rs1,
    input  logic [RA-1:0] ex_rs2,
    input  logic [RA-1:0] mem_rd,
    input  logic          mem_reg_write,
    input  logic [RA-1:0] wb_rd,
    input  logic          wb_reg_write,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b
);
    logic mem_ok, wb_ok;
    assign mem_ok = mem_reg_write && mem_rd != '0;
    assign wb_ok  = wb_reg_write && wb_rd != '0;
    always_comb begin
        fwd_a = (mem_ok && mem_rd == ex_rs1) ? FWD_MEM : (wb_ok && wb_rd == ex_rs1) ? FWD_WB : FWD_REG;
        fwd_b = (mem_ok && mem_rd == ex_rs2) ? FWD_MEM : (wb_ok && wb_rd == ex_rs2) ? FWD_WB : FWD_REG;
    end
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: hazard/sequencing FSM driving stage enables, flushes, PC select and forwarding
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int REGISTER_FILE_ADDRESS_WIDTH = 5,
    parameter int RESET_FLUSH_CYCLES = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int STALL_COUNT_WIDTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] id_rs1,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] id_rs2,
    input  logic                                   id_uses_rs1,
    input  logic                                   id_uses_rs2,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ex_rs1,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ex_rs2,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] ex_rd,
    input  logic                                   ex_mem_read,
    input  logic                                   ex_branch_taken,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] mem_rd,
    input  logic                                   mem_reg_write,
    input  logic                                   dmem_req,
    input  logic                                   dmem_ack,
    input  logic [REGISTER_FILE_ADDRESS_WIDTH-1:0] wb_rd,
    input  logic                                   wb_reg_write,
    input  logic                                   wb_halt,
    output logic                                   pc_en,
    output logic                                   if_id_en,
    output logic                                   id_ex_en,
    output logic                                   ex_mem_en,
    output logic                                   mem_wb_en,
    output logic                                   if_id_flush,
    output logic                                   id_ex_flush,
    output logic                                   ex_mem_flush,
    output logic                                   mem_wb_flush,
    output logic                                   pc_sel,
    output logic [1:0]                             fwd_a,
    output logic [1:0]                             fwd_b,
    output logic                                   halted,
    output logic                                   mem_fault,
    output logic [STALL_COUNT_WIDTH-1:0]           stall_count
);
    ctrl_state_t state_q, state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic [STALL_COUNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic halted_q, halted_d, mem_fault_q, mem_fault_d;
    logic active, drain, mem_stall, run, load_use, timeout;

    assign active    = state_q == S_RUN || state_q == S_MEM_WAIT;
    assign drain     = state_q == S_DRAIN;
    assign mem_stall = dmem_req && !dmem_ack;
    assign run       = active && !mem_stall;
    assign load_use  = ex_mem_read && ex_rd != '0 &&
                       ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    assign timeout   = !dmem_ack && wait_cnt_q == 8'(MEM_TIMEOUT - 1);

    // Priority: memory freeze, then taken branch (wrong-path ID masks load-use), then load-use
    always_comb begin
        pc_en        = run && (ex_branch_taken || !load_use);
        if_id_en     = run && (ex_branch_taken || !load_use);
        id_ex_en     = run;
        ex_mem_en    = run;
        mem_wb_en    = active;
        pc_sel       = run && ex_branch_taken;
        if_id_flush  = drain || (run && ex_branch_taken);
        id_ex_flush  = drain || (run && (ex_branch_taken || load_use));
        ex_mem_flush = drain;
        mem_wb_flush = drain || (active && mem_stall);
    end

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = '0;
        wait_cnt_d    = '0;
        mem_fault_d   = mem_fault_q;
        stall_count_d = (active && !pc_en && stall_count_q != '1) ? stall_count_q + 1'b1 : stall_count_q;
        case (state_q)
            S_DRAIN: begin
                drain_cnt_d = drain_cnt_q + 4'd1;
                state_d     = drain_cnt_q == 4'(RESET_FLUSH_CYCLES - 1) ? S_RUN : S_DRAIN;
            end
            S_RUN:
                state_d = wb_halt ? S_HALT : mem_stall ? S_MEM_WAIT : S_RUN;
            S_MEM_WAIT: begin
                wait_cnt_d  = wait_cnt_q + 8'd1;
                mem_fault_d = timeout;
                state_d     = (timeout || wb_halt) ? S_HALT : dmem_ack ? S_RUN : S_MEM_WAIT;
            end
            default:
                state_d = S_HALT;
        endcase
        halted_d = state_d == S_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst == RESET) begin
            state_q       <= S_DRAIN;
            drain_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            stall_count_q <= '0;
            halted_q      <= 1'b0;
            mem_fault_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_count_q <= stall_count_d;
            halted_q      <= halted_d;
            mem_fault_q   <= mem_fault_d;
        end
    end

    assign halted      = halted_q;
    assign mem_fault   = mem_fault_q;
    assign stall_count = stall_count_q;

    forwarding_unit #(.RA(REGISTER_FILE_ADDRESS_WIDTH)) u_fwd (
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: scenario tasks with a scoreboard of expected control vectors per cycle
module tb_pipeline_controller;
    localparam int RA = 5, SW = 16, MT = 16, RFC = 4;

    logic clk = 1'b0, rst;
    logic [RA-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_reg_write;
    logic dmem_req, dmem_ack, wb_reg_write, wb_halt;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel, halted, mem_fault;
    logic [1:0] fwd_a, fwd_b;
    logic [SW-1:0] stall_count;

    always #5 clk = ~clk;

    pipeline_controller #(
        .REGISTER_FILE_ADDRESS_WIDTH(RA), .RESET_FLUSH_CYCLES(RFC),
        .MEM_TIMEOUT(MT), .STALL_COUNT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_halt(wb_halt), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .pc_sel(pc_sel), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .mem_fault(mem_fault), .stall_count(stall_count)
    );

    // {pc,ifid,idex,exmem,memwb enables | ifid,idex,exmem,memwb flushes | pc_sel | halted,mem_fault | fwd_a | fwd_b}
    logic [15:0] obs;
    assign obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush,
                  ex_mem_flush, mem_wb_flush, pc_sel, halted, mem_fault, fwd_a, fwd_b};

    localparam logic [15:0] C_DRAIN = 16'b00000_1111_0_00_0000;
    localparam logic [15:0] C_RUN   = 16'b11111_0000_0_00_0000;
    localparam logic [15:0] C_LU    = 16'b00111_0100_0_00_0000;
    localparam logic [15:0] C_BR    = 16'b11111_1100_1_00_0000;
    localparam logic [15:0] C_MS    = 16'b00000_0001_0_00_0000;
    localparam logic [15:0] C_HALT  = 16'b00000_0000_0_10_0000;
    localparam logic [15:0] C_FAULT = 16'b00000_0000_0_11_0000;
    localparam logic [15:0] M_ALL   = 16'hFFFF;
    localparam logic [15:0] M_LU    = ~16'b00100_0000_0_00_0000;
    localparam logic [15:0] M_MS    = ~16'b00001_0000_0_00_0000;

    typedef struct {
        string       name;
        logic [15:0] ctrl;
        logic [15:0] mask;
        logic [SW-1:0] stalls;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int errors = 0, checks = 0;
    logic [SW-1:0] exp_stall;

    task automatic idle_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_reg_write} = '0;
        {dmem_req, dmem_ack, wb_reg_write, wb_halt} = '0;
    endtask

    task automatic expect_cycle(input string n, input logic [15:0] c, input logic [15:0] m);
        sb.push_back('{n, c, m, exp_stall});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (RFC) @(negedge clk);
        exp_stall = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        exp_stall = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < RFC + 2; i++) begin
            expect_cycle(i < RFC ? "reset_drain" : "reset_run", i < RFC ? C_DRAIN : C_RUN, M_ALL);
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.ctrl & e.mask) || stall_count !== e.stalls) begin
                errors++;
                $display("FAIL %s cycle %0d: got ctrl=%b stalls=%0d, want ctrl=%b stalls=%0d",
                         e.name, i, obs & e.mask, stall_count, e.ctrl & e.mask, e.stalls);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (i == 0 || i == 2) begin
                ex_mem_read = 1'b1;
                id_uses_rs2 = 1'b1;
                ex_rd       = (i == 0) ? 5'd5 : 5'd0;
                id_rs2      = ex_rd;
            end
            expect_cycle(i == 0 ? "load_use" : i == 2 ? "load_use_rd0" : "load_use_after",
                         i == 0 ? C_LU : C_RUN, i == 0 ? M_LU : M_ALL);
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.ctrl & e.mask) || stall_count !== e.stalls) begin
                errors++;
                $display("FAIL %s: got ctrl=%b stalls=%0d, want ctrl=%b stalls=%0d",
                         e.name, obs & e.mask, stall_count, e.ctrl & e.mask, e.stalls);
            end
            if (i == 0) exp_stall++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch_load_use();
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            if (i == 0) begin
                {ex_mem_read, id_uses_rs2, ex_branch_taken} = 3'b111;
                ex_rd  = 5'd5;
                id_rs2 = 5'd5;
            end
            expect_cycle(i == 0 ? "branch_over_load_use" : "branch_after", i == 0 ? C_BR : C_RUN, M_ALL);
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.ctrl & e.mask) || stall_count !== e.stalls) begin
                errors++;
                $display("FAIL %s: got ctrl=%b stalls=%0d, want ctrl=%b stalls=%0d",
                         e.name, obs & e.mask, stall_count, e.ctrl & e.mask, e.stalls);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_wait();
        // Three frozen cycles, ack, one idle cycle, then an access that never completes
        for (int i = 0; i < 5 + MT + 1 + 3; i++) begin
            idle_inputs();
            dmem_req = (i < 4) || (i >= 5 && i < 5 + MT + 1);
            dmem_ack = (i == 3);
            if (i < 3 || (i >= 5 && i < 5 + MT + 1))
                expect_cycle("mem_stall", C_MS, M_MS);
            else if (i < 5)
                expect_cycle(i == 3 ? "mem_ack" : "mem_resume", C_RUN, M_ALL);
            else
                expect_cycle("mem_timeout_halt", C_FAULT, M_ALL);
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.ctrl & e.mask) || stall_count !== e.stalls) begin
                errors++;
                $display("FAIL %s cycle %0d: got ctrl=%b stalls=%0d, want ctrl=%b stalls=%0d",
                         e.name, i, obs & e.mask, stall_count, e.ctrl & e.mask, e.stalls);
            end
            if (e.ctrl == C_MS) exp_stall++;
            @(negedge clk);
        end
        do_reset();
    endtask

    task automatic test_forwarding();
        // {mem_rd, mem_we, wb_rd, wb_we, ex_rs1, ex_rs2, fwd_a, fwd_b}
        logic [25:0] tbl [4];
        logic [25:0] t;
        tbl[0] = {5'd7, 1'b1, 5'd7, 1'b1, 5'd7, 5'd3, 2'b10, 2'b00};
        tbl[1] = {5'd7, 1'b0, 5'd7, 1'b1, 5'd7, 5'd3, 2'b01, 2'b00};
        tbl[2] = {5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 5'd3, 2'b01, 2'b10};
        tbl[3] = {5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 2'b00, 2'b00};
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            t = tbl[i];
            {mem_rd, mem_reg_write, wb_rd, wb_reg_write, ex_rs1, ex_rs2} = t[25:4];
            expect_cycle("forwarding", C_RUN | {12'b0, t[3:0]}, M_ALL);
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.ctrl & e.mask) || stall_count !== e.stalls) begin
                errors++;
                $display("FAIL %s row %0d: got ctrl=%b stalls=%0d, want ctrl=%b stalls=%0d",
                         e.name, i, obs & e.mask, stall_count, e.ctrl & e.mask, e.stalls);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            wb_halt         = (i == 0);
            ex_branch_taken = (i == 2);
            rst             = (i == 3);
            expect_cycle(i == 0 ? "halt_wb" : i < 4 ? "halt_hold" : "halt_reset",
                         i == 0 ? C_RUN : i < 4 ? C_HALT : C_DRAIN, M_ALL);
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.ctrl & e.mask) || stall_count !== e.stalls) begin
                errors++;
                $display("FAIL %s cycle %0d: got ctrl=%b stalls=%0d, want ctrl=%b stalls=%0d",
                         e.name, i, obs & e.mask, stall_count, e.ctrl & e.mask, e.stalls);
            end
            if (i == 3) exp_stall = '0;
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (RFC) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        // Two load-use stalls, then a memory stall that must mask a taken branch, then normal
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            if (i < 2) begin
                {ex_mem_read, id_uses_rs1} = 2'b11;
                ex_rd  = 5'd9;
                id_rs1 = 5'd9;
            end
            if (i == 2) {dmem_req, ex_branch_taken} = 2'b11;
            if (i == 3) dmem_ack = 1'b1;
            expect_cycle(i < 2 ? "b2b_load_use" : i == 2 ? "b2b_mem_over_branch" : "b2b_ack",
                         i < 2 ? C_LU : i == 2 ? C_MS : C_RUN, i < 2 ? M_LU : i == 2 ? M_MS : M_ALL);
            #1;
            e = sb.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.ctrl & e.mask) || stall_count !== e.stalls) begin
                errors++;
                $display("FAIL %s cycle %0d: got ctrl=%b stalls=%0d, want ctrl=%b stalls=%0d",
                         e.name, i, obs & e.mask, stall_count, e.ctrl & e.mask, e.stalls);
            end
            if (i < 3) exp_stall++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_forwarding();
        test_back_to_back();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_controller.md
Name: pipeline_controller

Overview:
Central hazard and sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB). It drives the enable and flush signals of the PC and of every inter-stage pipeline register, plus the EX-stage operand forwarding selects. It runs a post-reset pipeline-drain sequence, detects load-use hazards, redirects on taken branches, freezes the pipe while the data memory is busy, and halts the core on a halt instruction or a memory timeout. It sits beside the stage modules in risc_v; the stages consume its outputs.

Parameters:
REGISTER_FILE_ADDRESS_WIDTH, 5, width of the rs/rd register indices
RESET_FLUSH_CYCLES, 4, number of cycles all stages are flushed after reset (range 1..15)
MEM_TIMEOUT, 16, maximum consecutive data-memory wait cycles before fault (range 1..255)
STALL_COUNT_WIDTH, 16, width of the stall performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
id_rs1, id_rs2  in  RA  source registers of the instruction in ID (RA = REGISTER_FILE_ADDRESS_WIDTH)
id_uses_rs1, id_uses_rs2  in  1  instruction in ID reads rs1 / rs2
ex_rs1, ex_rs2  in  RA  source registers of the instruction in EX
ex_rd  in  RA  destination register in EX
ex_mem_read  in  1  instruction in EX is a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_rd  in  RA  destination register in MEM
mem_reg_write  in  1  instruction in MEM writes rd
dmem_req  in  1  MEM stage is issuing a data-memory access
dmem_ack  in  1  data memory completes the access this cycle
wb_rd  in  RA  destination register in WB
wb_reg_write  in  1  instruction in WB writes rd
wb_halt  in  1  halt instruction is in WB
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  insert a bubble (flush wins over enable)
pc_sel  out  1  1 = PC loads the branch target, 0 = PC+4
fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB result, 10 MEM result
halted  out  1  core stopped
mem_fault  out  1  halt was caused by a memory timeout
stall_count  out  STALL_COUNT_WIDTH  saturating count of stall cycles

Behaviour:
- FSM states: S_DRAIN, S_RUN, S_MEM_WAIT, S_HALT. rst forces S_DRAIN, drain counter 0, wait counter 0, stall_count 0, mem_fault 0.
- S_DRAIN: all enables 0, all flushes 1, pc_sel 0. After RESET_FLUSH_CYCLES cycles go to S_RUN. PC reset itself is owned by IF.
- S_RUN / S_MEM_WAIT control outputs are combinational from the inputs, evaluated in this priority:
  1) mem_stall = dmem_req && !dmem_ack: pc_en, if_id_en, id_ex_en and ex_mem_en are 0; mem_wb_flush=1; other flushes 0. Branch and load-use are ignored this cycle because they stay held in the frozen registers.
  2) ex_branch_taken: pc_en=1, pc_sel=1, if_id_flush=1, id_ex_flush=1, other enables 1. A simultaneous load-use is ignored because the ID instruction is wrong-path.
  3) load_use = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1.
  4) otherwise: all enables 1, all flushes 0, pc_sel 0.
- A zero-wait access (dmem_req and dmem_ack in the same cycle) causes no stall.
- S_RUN -> S_MEM_WAIT when mem_stall. S_MEM_WAIT -> S_RUN on the cycle dmem_ack=1.
- The wait counter counts cycles spent in S_MEM_WAIT. If it reaches MEM_TIMEOUT with no ack, go to S_HALT and set mem_fault=1.
- wb_halt in S_RUN or S_MEM_WAIT: go to S_HALT on the next edge. The halting instruction's WB completes that cycle because mem_wb_en is unaffected.
- S_HALT: all enables 0, flushes 0, halted=1. Only rst exits.
- fwd_a = 10 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1; else 01 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1; else 00. fwd_b uses the same rule with ex_rs2. Forwarding is active in all states (don't-care outside S_RUN / S_MEM_WAIT).
- stall_count increments in S_RUN / S_MEM_WAIT on any cycle with pc_en=0. It saturates at all-ones.
- halted and mem_fault are registered. All other control outputs are combinational.
- rst mid-operation (any state) returns to S_DRAIN on the next edge.

Decomposition:
- Package common:
  - ctrl_state_t enum {S_DRAIN, S_RUN, S_MEM_WAIT, S_HALT}
  - fwd_sel_t enum {FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}
  - the existing RESET constant
- Sub-module forwarding_unit: purely combinational fwd_a/fwd_b logic, instantiated once. The FSM, priority logic and counters stay in pipeline_controller.

Test Plan:
1. Reset drain: rst=1 for 2 cycles then 0 -> all flushes 1 and pc_en 0 for exactly 4 cycles, then pc_en=1, halted=0, stall_count=0.
2. Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1, stall_count=1. Repeat with ex_rd=0 -> no stall.
3. Branch + load-use together: ex_branch_taken=1 with the case-2 hazard -> pc_sel=1, pc_en=1, if_id_flush=1, id_ex_flush=1, stall_count unchanged.
4. Memory wait: dmem_req=1, ack after 3 cycles -> 3 frozen cycles with mem_wb_flush=1, back to S_RUN on the ack cycle, stall_count=3. Holding ack=0 for 16 cycles -> halted=1, mem_fault=1.
5. Forwarding: mem_rd=wb_rd=7 with both write enables set, ex_rs1=7 -> fwd_a=10. Clear mem_reg_write -> fwd_a=01. Set ex_rs2=0 with rd 0 -> fwd_b=00.
6. Halt: wb_halt=1 -> halted=1 next cycle, all enables 0 and held. rst=1 -> S_DRAIN, halted=0.
